// File: rtl/uart_rx.sv
// uart_rx: serial receiver for 8E1 frames (start 0, 8 data bits LSB first,
// even parity, stop 1). Each sample is taken HALF_BIT cycles into its bit.
// A completed frame updates RX_data_out and the error flags and pulses
// RX_valid for one cycle. The consumer is expected to take the byte in the
// RX_valid cycle; there is no ready/backpressure path, and the next frame
// overwrites the byte.
// Optional build macro UART_RX_SYNC_EN: when it is defined, the line passes
// through a 2-flop synchronizer reset to 1, which adds 2 cycles to every event.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX_data_in,
  output logic [7:0] RX_data_out,
  output logic       RX_valid,
  output logic       RX_parity_err,
  output logic       RX_frame_err,
  output logic       RX_busy,
  output logic [2:0] o_dbg_state
);

  localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'((HALF_BIT > 0) ? (HALF_BIT - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_line;
  logic            w_tick;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_par;
  logic            r_perr;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_perr_out;
  logic            r_ferr_out;
  logic            r_busy;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;
  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], RX_data_in};
  end
  assign w_line = r_sync[1];
`else
  assign w_line = RX_data_in;
`endif

  // The sample point of the current bit is reached when the countdown hits 0
  assign w_tick = (r_cnt == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; with HALF_BIT=0 the start sample is the detection cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!w_line) w_next = (HALF_BIT == 0) ? S_DATA : S_START;
      S_START:  if (w_tick) w_next = w_line ? S_IDLE : S_DATA;
      S_DATA:   if (w_tick && (r_bit == 3'd7)) w_next = S_PARITY;
      S_PARITY: if (w_tick) w_next = S_STOP;
      S_STOP:   if (w_tick) w_next = w_line ? S_IDLE : S_BREAK;
      S_BREAK:  if (w_line) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Bit timing, shift/parity accumulation and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_bit      <= 3'd0;
      r_shift    <= 8'd0;
      r_par      <= 1'b0;
      r_perr     <= 1'b0;
      r_data     <= 8'd0;
      r_valid    <= 1'b0;
      r_perr_out <= 1'b0;
      r_ferr_out <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_line) begin
            r_busy <= 1'b1;
            r_bit  <= 3'd0;
            r_par  <= 1'b0;
            r_cnt  <= (HALF_BIT == 0) ? C_BIT_LAST : C_HALF_LAST;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_cnt <= C_BIT_LAST;
            if (w_line) r_busy <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= {w_line, r_shift[7:1]};
            r_par   <= r_par ^ w_line;
            r_bit   <= r_bit + 3'd1;
            r_cnt   <= C_BIT_LAST;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_perr <= r_par ^ w_line;
            r_cnt  <= C_BIT_LAST;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_data     <= r_shift;
            r_perr_out <= r_perr;
            r_ferr_out <= ~w_line;
            r_valid    <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign RX_data_out   = r_data;
  assign RX_valid      = r_valid;
  assign RX_parity_err = r_perr_out;
  assign RX_frame_err  = r_ferr_out;
  assign RX_busy       = r_busy;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives two receivers (CLKS_PER_BIT=1 and 16) with directed
// table vectors, hand-built corner sequences and random frame streams.
// Every cycle is compared against a timeline derived from the frame sample
// rules (sample k of a frame lands at t0 + HALF_BIT + k*CLKS_PER_BIT).
`timescale 1ns/1ps
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       line1, line16;
  logic [7:0] d1_data, d16_data;
  logic       d1_valid, d16_valid, d1_perr, d16_perr, d1_ferr, d16_ferr;
  logic       d1_busy, d16_busy;
  logic [2:0] d1_state, d16_state;

  uart_rx #(.CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .RX_data_in(line1), .RX_data_out(d1_data),
    .RX_valid(d1_valid), .RX_parity_err(d1_perr), .RX_frame_err(d1_ferr),
    .RX_busy(d1_busy), .o_dbg_state(d1_state)
  );

  uart_rx #(.CLKS_PER_BIT(16)) u_dut16 (
    .clk(clk), .rst(rst), .RX_data_in(line16), .RX_data_out(d16_data),
    .RX_valid(d16_valid), .RX_parity_err(d16_perr), .RX_frame_err(d16_ferr),
    .RX_busy(d16_busy), .o_dbg_state(d16_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  bit          stim_q[$];
  bit          mb[$];
  bit          mv[$];
  logic [9:0]  exp_q[$];   // {frame_err, parity_err, data}
  int          vq[$];
  logic [9:0]  got_q[$];
  logic [9:0]  held1 = '0;
  logic [9:0]  held16 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic add_level(input bit v, input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(v);
  endtask

  task automatic add_frame(input int cpb, input logic [7:0] d, input bit flip, input bit stop);
    bit bits[11];
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k+1] = d[k];
    bits[9]  = (^d) ^ flip;
    bits[10] = stop;
    for (int k = 0; k < 11; k++) add_level(bits[k], cpb);
  endtask

  function automatic bit lv(input int i);
    return (i < stim_q.size()) ? stim_q[i] : 1'b1;
  endfunction

  // ---------------- reference model ----------------
  // Walks the line as the receiver sees it, locating each start edge and the
  // sample cycles of that frame, and records expected busy/valid per cycle.
  task automatic build_model(input int cpb, input int len);
    int t, t0, ts, h, j;
    logic [7:0] d;
    bit p;
    mb.delete(); mv.delete(); exp_q.delete();
    for (int i = 0; i < len; i++) begin
      mb.push_back(1'b0);
      mv.push_back(1'b0);
    end
    h = (cpb - 1) / 2;
    t = 0;
    while (t < len) begin
      if (lv(t)) begin
        t++;
        continue;
      end
      t0 = t;
      if (lv(t0 + h)) begin
        for (int k = t0 + 1; k <= t0 + h && k < len; k++) mb[k] = 1'b1;
        t = t0 + h + 1;
        continue;
      end
      for (int k = 0; k < 8; k++) d[k] = lv(t0 + h + (k + 1) * cpb);
      p  = (^d) ^ lv(t0 + h + 9 * cpb);
      ts = t0 + h + 10 * cpb;
      for (int k = t0 + 1; k <= ts && k < len; k++) mb[k] = 1'b1;
      if (ts + 1 < len) mv[ts+1] = 1'b1;
      exp_q.push_back({~lv(ts), p, d});
      if (lv(ts)) t = ts + 1;
      else begin
        j = ts + 1;
        while (!lv(j)) j++;
        t = j + 1;
      end
    end
  endtask

  // Drive stim_q onto one receiver and compare it every cycle with the model
  task automatic run_seq(input bit sel16, input int cpb, input string tag);
    int len, m;
    bit ev, eb, ov, ob;
    logic [9:0] held, got;
    len = stim_q.size() + 11 * cpb + 4;
    build_model(cpb, len);
    vq.delete(); got_q.delete();
    held = sel16 ? held16 : held1;
    for (int i = 0; i < len + LAT; i++) begin
      @(posedge clk);
      #1;
      if (sel16) line16 = lv(i);
      else       line1  = lv(i);
      @(negedge clk);
      m  = i - LAT;
      ev = (m >= 0) ? mv[m] : 1'b0;
      eb = (m >= 0) ? mb[m] : 1'b0;
      if (ev && exp_q.size() > 0) held = exp_q.pop_front();
      ov  = sel16 ? d16_valid : d1_valid;
      ob  = sel16 ? d16_busy  : d1_busy;
      got = sel16 ? {d16_ferr, d16_perr, d16_data} : {d1_ferr, d1_perr, d1_data};
      check({tag, "_valid"}, 32'(ov), 32'(ev));
      check({tag, "_busy"},  32'(ob), 32'(eb));
      check({tag, "_outs"},  32'(got), 32'(held));
      if (ov) begin
        vq.push_back(i);
        got_q.push_back(got);
      end
    end
    check({tag, "_exp_left"}, exp_q.size(), 0);
    if (sel16) held16 = held;
    else       held1  = held;
    stim_q.delete();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         sel16;
    logic [7:0] data;
    bit         flip;
    bit         stop;
    int         gap;
    logic [9:0] exp_rec;
  } vec_t;

  vec_t vt[7];

  initial begin
    #20_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cpb, h;
    logic [7:0] rb;
    vt[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 3, 10'h0A5};
    vt[1] = '{1'b0, 8'h01, 1'b1, 1'b1, 2, 10'h101};
    vt[2] = '{1'b0, 8'hC3, 1'b0, 1'b0, 1, 10'h2C3};
    vt[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 10'h000};
    vt[4] = '{1'b1, 8'h55, 1'b0, 1'b1, 5, 10'h055};
    vt[5] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1, 10'h0FF};
    vt[6] = '{1'b1, 8'h80, 1'b1, 1'b1, 2, 10'h180};

    // reset state
    rst = 1'b1; line1 = 1'b1; line16 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data1",  32'(d1_data), 0);
    check("rst_valid1", 32'(d1_valid), 0);
    check("rst_flags1", 32'({d1_perr, d1_ferr}), 0);
    check("rst_busy1",  32'(d1_busy), 0);
    check("rst_state1", 32'(d1_state), 0);
    check("rst_data16", 32'(d16_data), 0);
    check("rst_outs16", 32'({d16_valid, d16_perr, d16_ferr, d16_busy}), 0);
    check("rst_state16", 32'(d16_state), 0);
    @(negedge clk);
    rst = 1'b0;

    // table vectors
    for (int v = 0; v < 7; v++) begin
      cpb = vt[v].sel16 ? 16 : 1;
      h   = (cpb - 1) / 2;
      add_level(1'b1, vt[v].gap);
      add_frame(cpb, vt[v].data, vt[v].flip, vt[v].stop);
      add_level(1'b1, 4);
      run_seq(vt[v].sel16, cpb, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_count", v), got_q.size(), 1);
      if (got_q.size() > 0) begin
        check($sformatf("vec%0d_rec", v), 32'(got_q[0]), 32'(vt[v].exp_rec));
        check($sformatf("vec%0d_time", v), vq[0], vt[v].gap + h + 10 * cpb + 1 + LAT);
      end
    end

    // framing error with a held-low line, then a clean frame
    add_level(1'b1, 2);
    add_frame(16, 8'h3C, 1'b0, 1'b0);
    add_level(1'b0, 40);
    add_level(1'b1, 5);
    add_frame(16, 8'h55, 1'b0, 1'b1);
    add_level(1'b1, 4);
    run_seq(1'b1, 16, "brk");
    check("brk_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("brk_rec0", 32'(got_q[0]), 32'h23C);
      check("brk_rec1", 32'(got_q[1]), 32'h055);
    end

    // short low glitch on an idle line, then 0xFF
    add_level(1'b1, 2);
    add_level(1'b0, 3);
    add_level(1'b1, 20);
    add_frame(16, 8'hFF, 1'b0, 1'b1);
    add_level(1'b1, 4);
    run_seq(1'b1, 16, "glitch");
    check("glitch_count", got_q.size(), 1);
    if (got_q.size() > 0) check("glitch_rec", 32'(got_q[0]), 32'h0FF);

    // back-to-back frames with no idle gap
    add_level(1'b1, 1);
    add_frame(1, 8'h12, 1'b0, 1'b1);
    add_frame(1, 8'h34, 1'b0, 1'b1);
    add_level(1'b1, 4);
    run_seq(1'b0, 1, "b2b");
    check("b2b_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("b2b_gap",  vq[1] - vq[0], 11);
      check("b2b_rec0", 32'(got_q[0]), 32'h012);
      check("b2b_rec1", 32'(got_q[1]), 32'h034);
    end

    // reset at t0+5 of a frame
    rb = 8'h5A;
    @(posedge clk);
    #1 line1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 line1 = rb[k];
    end
    #1;
    check("rst_mid_busy_pre", 32'(d1_busy), (LAT == 0) ? 1 : 1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_data",  32'(d1_data), 0);
    check("rst_mid_valid", 32'(d1_valid), 0);
    check("rst_mid_flags", 32'({d1_perr, d1_ferr}), 0);
    check("rst_mid_busy",  32'(d1_busy), 0);
    line1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    held1 = '0;
    held16 = '0;
    add_level(1'b1, 3);
    add_frame(1, 8'h7E, 1'b0, 1'b1);
    add_level(1'b1, 4);
    run_seq(1'b0, 1, "post_rst");
    check("post_rst_count", got_q.size(), 1);
    if (got_q.size() > 0) check("post_rst_rec", 32'(got_q[0]), 32'h07E);

    // random frame streams on both receivers
    for (int s = 0; s < 2; s++) begin
      cpb = (s == 1) ? 16 : 1;
      for (int f = 0; f < 12; f++) begin
        bit stop;
        add_level(1'b1, $urandom_range(0, 3));
        if (cpb == 16 && $urandom_range(0, 4) == 0) begin
          add_level(1'b0, $urandom_range(1, 4));
          add_level(1'b1, 12);
        end
        stop = ($urandom_range(0, 4) != 0);
        add_frame(cpb, 8'($urandom), ($urandom_range(0, 3) == 0), stop);
        if (!stop) begin
          add_level(1'b0, $urandom_range(0, 6));
          add_level(1'b1, $urandom_range(1, 3));
        end
      end
      add_level(1'b1, 4);
      run_seq(s == 1, cpb, $sformatf("rand%0d", cpb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver, the downstream stage of the transmit path; consumes the single-wire line driven by the transmitter's serial output.
- Frame format: start (0), 8 data bits LSB first, even parity bit (XOR of data), stop (1).
- Recovers each byte, checks parity and stop bit, and presents the byte with a one-cycle valid strobe.
- CLKS_PER_BIT=1 allows a direct clk-for-clk connection to the transmitter.

Parameters:
- CLKS_PER_BIT, 1, clock cycles per serial bit (>=1). Bit counter width is $clog2(CLKS_PER_BIT)+1.
- HALF_BIT, (CLKS_PER_BIT-1)/2, integer offset from bit start to the sample point; derived localparam, not overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- RX_data_in  input  1  serial line, idles high
- RX_data_out  output  8  last received byte; held until the next frame completes
- RX_valid  output  1  one-cycle pulse: frame complete, outputs updated
- RX_parity_err  output  1  parity mismatch for the frame flagged by RX_valid; held with data
- RX_frame_err  output  1  stop bit sampled 0 for that frame; held with data
- RX_busy  output  1  high while a frame is being received

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-high, named rst, clock named clk. Reset forces state IDLE, all outputs 0 and counters 0. Reset mid-frame aborts the frame with no RX_valid.
- States:
  - IDLE: waits for the line.
  - START: confirms the start bit.
  - DATA: 8 bits.
  - PARITY
  - STOP
  - BREAK: waits for the line to return high.
- IDLE->START: the first cycle t0 in which the (synchronized) line reads 0. RX_busy rises in the cycle after t0 (registered).
- Sample k (0=start, 1..8=data, 9=parity, 10=stop) is taken at cycle t0+HALF_BIT+k*CLKS_PER_BIT. With CLKS_PER_BIT=1 this is t0+k; sample 0 is the detection cycle itself.
- START: if the line reads 1 at sample 0, it is a glitch. Return to IDLE with no output, and RX_busy drops the next cycle.
- DATA: sample k shifts into bit k-1, so the first data bit is the LSB. Running XOR is accumulated.
- PARITY: parity_err = running XOR of data XOR the sampled parity bit.
- STOP: at sample 10, register RX_data_out, RX_parity_err, and RX_frame_err = ~line. Pulse RX_valid high the next cycle and drop RX_busy in that same cycle.
- RX_valid fires even when error flags are set; the consumer decides what to do.
- After a good stop bit: go to IDLE. A new start can be detected in the cycle right after the stop sample, which supports back-to-back frames from the transmitter.
- After a framing error: go to BREAK. Stay there while the line is 0; move to IDLE on the first 1. A held-low line yields exactly one frame_err frame, not a stream.
- Output stability: RX_data_out and the error flags change only in the RX_valid cycle.
- No backpressure. If the consumer misses RX_valid, the byte is overwritten by the next frame.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: RX_data_in passes through a 2-flop synchronizer reset to 1. Every line event is seen 2 cycles later, so all sample points and RX_valid shift by +2 cycles.
- Undefined: the line is used directly, for on-chip connection to the transmitter in the same clock domain, with zero added latency.

Test Plan:
- CLKS_PER_BIT=1, drive the frame for 0xA5 (0,1,0,1,0,0,1,0,1, parity 0, stop 1) starting at t0. Required: RX_valid at t0+11, RX_data_out=0xA5, both error flags 0, RX_busy high t0+1..t0+10.
- CLKS_PER_BIT=1, 0x01 with parity bit forced to 0. Required: RX_valid with RX_data_out=0x01, RX_parity_err=1, RX_frame_err=0.
- CLKS_PER_BIT=16, 0x3C with stop bit low, line held low for 40 more cycles, then high, then 0x55. Required:
  - 0x3C frame: RX_frame_err=1, exactly one RX_valid while the line is low.
  - 0x55 frame: received correctly with errors cleared.
- CLKS_PER_BIT=16, 3-cycle low glitch on an idle line. Required: no RX_valid; RX_busy high only briefly; the next real frame 0xFF is received with parity_err=0.
- CLKS_PER_BIT=1, two back-to-back frames 0x12 then 0x34 with no idle gap. Required: RX_valid pulses 11 cycles apart with data 0x12 then 0x34.
- Assert rst at t0+5 of a frame. Required:
  - All outputs 0 immediately, no RX_valid.
  - The next frame 0x7E after release is received correctly.
- Repeat scenario 1 with UART_RX_SYNC_EN defined. Required: RX_valid at t0+13.
